// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// alu_seq_if : operand/result handshake bundle between decode and alu_seq.
// Rev 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       mode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_err;

    modport master (
        output in_valid, mode, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_hi, flag_zero, flag_carry, flag_err
    );

    modport slave (
        input  in_valid, mode, in1, in2, out_ready,
        output in_ready, out_valid, out, out_hi, flag_zero, flag_carry, flag_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : clocked ALU, valid/ready in and out, registered result and flags.
//           Macro ALU_MUL_EN adds a WIDTH-cycle shift-add multiplier on mode 110.
// Rev 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [2:0] C_ADD = 3'd0;
    localparam logic [2:0] C_SUB = 3'd1;
    localparam logic [2:0] C_CMP = 3'd2;
    localparam logic [2:0] C_AND = 3'd3;
    localparam logic [2:0] C_OR  = 3'd4;
    localparam logic [2:0] C_XOR = 3'd5;

`ifdef ALU_MUL_EN
    localparam logic [1:0]       C_BUSY = 2'd1;
    localparam logic [2:0]       C_MUL  = 3'd6;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic             w_accept;
    logic             w_load_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_carry;
    logic             w_err;

    assign w_accept = bus.in_valid & (state_q == C_IDLE);
    assign w_sum    = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign w_diff   = {1'b0, bus.in2} - {1'b0, bus.in1};

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_prod_step;
    logic               w_last;

    // Product register starts as {0, multiplier}; each step adds the
    // multiplicand into the upper half when the LSB is set, then shifts right.
    assign w_addend      = prod_q[0] ? mcand_q : '0;
    assign w_upper       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_prod_step   = {w_upper, prod_q[WIDTH-1:1]};
    assign w_last        = (state_q == C_BUSY) && (cnt_q == C_LAST);
    assign w_load_single = w_accept & (bus.mode != C_MUL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            hi_q <= hi_d;
            if (w_accept) begin
                prod_q  <= {{WIDTH{1'b0}}, bus.in2};
                mcand_q <= bus.in1;
                cnt_q   <= '0;
            end else if (state_q == C_BUSY) begin
                prod_q  <= w_prod_step;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_hi = hi_q;
`else
    assign w_load_single = w_accept;
    assign bus.out_hi    = '0;
`endif

    // Mode 110 lands in the default arm; with the multiplier enabled it is
    // never loaded from here because accept routes it to BUSY instead.
    always_comb begin
        w_res   = '0;
        w_zero  = 1'b0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (bus.mode)
            C_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            C_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            C_CMP: begin
                w_zero  = (bus.in1 == bus.in2);
                w_carry = (bus.in1 < bus.in2);
            end
            C_AND:   w_res = bus.in1 & bus.in2;
            C_OR:    w_res = bus.in1 | bus.in2;
            C_XOR:   w_res = bus.in1 ^ bus.in2;
            default: w_err = 1'b1;
        endcase
        if (!w_err && (bus.mode != C_CMP)) begin
            w_zero = (w_res == '0);
        end
    end

    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = err_q;
`ifdef ALU_MUL_EN
        hi_d    = hi_q;
`endif
        if (w_load_single) begin
            res_d   = w_res;
            zero_d  = w_zero;
            carry_d = w_carry;
            err_d   = w_err;
`ifdef ALU_MUL_EN
            hi_d    = '0;
        end else if (w_last) begin
            res_d   = w_prod_step[WIDTH-1:0];
            hi_d    = w_prod_step[2*WIDTH-1:WIDTH];
            zero_d  = (w_prod_step == '0);
            carry_d = |w_prod_step[2*WIDTH-1:WIDTH];
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_MUL_EN
                    state_d = (bus.mode == C_MUL) ? C_BUSY : C_DONE;
`else
                    state_d = C_DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            C_BUSY: begin
                if (cnt_q == C_LAST) begin
                    state_d = C_DONE;
                end
            end
`endif
            C_DONE: begin
                if (bus.out_ready) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == C_IDLE);
        bus.out_valid = (state_q == C_DONE);
    end

    assign bus.out        = res_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_err   = err_q;

endmodule
`default_nettype wire
